ysyx_issue_ctrl: RTL
====================

Name: ysyx_issue_ctrl

Overview:
In-order issue controller between the IDU decode output and the EXU. It buffers decoded instructions in a small FIFO and holds a per-register scoreboard of pending writebacks. An instruction issues only when its source and destination registers are free. Serializing instructions (system, csr, ecall, ebreak, mret) issue only with the pipeline drained. It also applies redirect flushes.

Parameters:
REG_W, 4, architectural register index width (NR_REG = 2**REG_W)
PAYLOAD_W, 160, opaque decoded bundle width (pc, inst, ops, imm, ctrl), passed through unmodified
DEPTH, 2, FIFO entries, power of 2, >=2
MAX_INFLIGHT, 4, max issued-but-not-written-back instructions

Ports:
clock  in  1  clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  IDU has a decoded instruction
in_ready  out  1  FIFO can accept
in_payload  in  PAYLOAD_W  decoded bundle
in_rs1/in_rs2  in  REG_W each  source indices
in_rs1_en/in_rs2_en  in  1 each  source used
in_rd  in  REG_W  destination
in_rd_en  in  1  writes rd
in_serial  in  1  serializing instruction
out_valid  out  1  head is issuable
out_ready  in  1  EXU accepts
out_payload  out  PAYLOAD_W  head bundle
wb_valid  in  1  one issued instruction retired or squashed
wb_rd  in  REG_W  its rd
wb_rd_en  in  1  it had set a pending bit
flush  in  1  redirect: drop all queued entries
inflight  out  clog2(MAX_INFLIGHT+1)  outstanding count
sb_err  out  1  sticky: wb with inflight==0

Behaviour:
- Reset (reset low, async): FIFO empty, pointers 0, pending all 0, inflight 0, serial_busy 0, sb_err 0.
- Reset values of outputs: in_ready=1, out_valid=0, out_payload=0.
- FIFO: in_ready = !full. Enqueue on in_valid&in_ready.
- Latency: an enqueue into an empty FIFO is visible as out_valid no earlier than the next cycle. There is no bypass.
- Simultaneous enqueue and dequeue when full is not allowed; in_ready already reflects full.
- Hazard (registered state only; no same-cycle wb bypass):
  - (rs1_en & pending[rs1])
  - | (rs2_en & pending[rs2])
  - | (rd_en & pending[rd]) (WAW)
  - | inflight==MAX_INFLIGHT
  - | serial_busy
  - | (head.serial & inflight!=0)
  - Register index 0 is never pending.
- out_valid = !empty & !hazard & !flush. It must not depend on out_ready.
- Issue (out_valid&out_ready): pop head. If rd_en & rd!=0, set pending[rd]. Increment inflight. If head.serial, set serial_busy.
- Writeback:
  - wb_valid & wb_rd_en & wb_rd!=0 clears pending[wb_rd].
  - If inflight>0, decrement inflight; otherwise set sb_err and leave inflight unchanged.
  - serial_busy clears when inflight becomes 0.
  - An issue and a wb in the same cycle give a net inflight change of 0.
  - If an issue sets and a wb clears the same register in the same cycle, the set wins.
- Flush:
  - Empties the FIFO at the edge. A same-cycle enqueue is dropped and no issue occurs.
  - Scoreboard, inflight and wb processing are unaffected. The EXU reports squashed issued instructions through wb.
- Stalled head: payload is held stable while out_valid=0 or out_ready=0.

Test Plan:
- Reset mid-stream with 2 entries queued and pending[5]=1 -> all state cleared asynchronously; in_ready=1, out_valid=0 on the following edge.
- Independent stream: 4 instrs, rd=1..4, no sources, out_ready=1 -> issues at cycles 1..4 back-to-back; inflight reaches 4 (MAX), then the 5th stalls until a wb arrives.
- RAW: instr A rd=3 issued; B rs1=3 -> out_valid=0 until the wb_rd=3 cycle; B issues the cycle after. x0 source never stalls.
- Same-cycle wb & issue: pending[3]=1 with inflight=1; wb rd=3 while C (rd=3) stalls; next cycle C issues while an unrelated wb arrives -> pending[3]=1, inflight unchanged.
- Serial: two instrs outstanding, head in_serial=1 -> waits for inflight=0, issues, then blocks the next instr until its wb.
- Flush with FIFO full plus in_valid=1 the same cycle -> FIFO empty, in_ready=1, no issue; stray wb with inflight=0 -> sb_err=1 and sticky until reset.

Source files
------------

// File: rtl/ysyx_issue_ctrl.sv
// ysyx_issue_ctrl: in-order issue stage between IDU decode and the EXU.
// A small FIFO holds decoded instructions. A per-register scoreboard of
// pending writebacks gates issue. The head issues only when its sources and
// destination are free, the in-flight window has room, and no serializing
// instruction is outstanding. A serializing head also needs the pipeline
// drained first.
//
// Ports:
//   clock, reset       clock, asynchronous active-low reset
//   in_*               decoded instruction from IDU (valid/ready handshake)
//   out_*              head instruction to EXU (valid/ready handshake)
//   wb_*               one issued instruction retired or squashed
//   flush              redirect: drop every queued (not yet issued) entry
//   inflight           issued-but-not-written-back count
//   sb_err             sticky: writeback seen while nothing was in flight
module ysyx_issue_ctrl #(
  parameter int REG_W        = 4,
  parameter int PAYLOAD_W    = 160,
  parameter int DEPTH        = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [PAYLOAD_W-1:0]               in_payload,
  input  logic [REG_W-1:0]                   in_rs1,
  input  logic [REG_W-1:0]                   in_rs2,
  input  logic                               in_rs1_en,
  input  logic                               in_rs2_en,
  input  logic [REG_W-1:0]                   in_rd,
  input  logic                               in_rd_en,
  input  logic                               in_serial,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [PAYLOAD_W-1:0]               out_payload,
  input  logic                               wb_valid,
  input  logic [REG_W-1:0]                   wb_rd,
  input  logic                               wb_rd_en,
  input  logic                               flush,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]  inflight,
  output logic                               sb_err
);
  localparam int NR_REG = 2 ** REG_W;
  localparam int PW     = $clog2(DEPTH);
  localparam int IW     = $clog2(MAX_INFLIGHT + 1);
  localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

  typedef struct packed {
    logic                 serial;
    logic                 rd_en;
    logic [REG_W-1:0]     rd;
    logic                 rs2_en;
    logic [REG_W-1:0]     rs2;
    logic                 rs1_en;
    logic [REG_W-1:0]     rs1;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             head;
  logic [PW:0]        wr_ptr, rd_ptr;
  logic               empty, full, enq, issue, hazard, wb_dec;
  logic [NR_REG-1:0]  pending, pending_nxt;
  logic [IW-1:0]      inflight_nxt;
  logic               serial_busy;

  // Extra pointer bit distinguishes full from empty when indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head  = mem[rd_ptr[PW-1:0]];

  assign in_ready = !full;
  assign enq      = in_valid & in_ready & ~flush;

  // Hazards look only at registered state; a same-cycle writeback does not
  // unblock the head until the following cycle.
  assign hazard = (head.rs1_en & pending[head.rs1])
                | (head.rs2_en & pending[head.rs2])
                | (head.rd_en  & pending[head.rd])
                | (inflight == IW'(MAX_INFLIGHT))
                | serial_busy
                | (head.serial & (inflight != '0));

  assign out_valid   = !empty & !hazard & !flush;
  assign issue       = out_valid & out_ready;
  assign out_payload = empty ? '0 : head.payload;

  // A stray writeback with nothing in flight is flagged, not counted.
  assign wb_dec       = wb_valid & (inflight != '0);
  assign inflight_nxt = inflight + IW'(issue) - IW'(wb_dec);

  // Clear before set so an issue claiming the register being released wins.
  always_comb begin
    pending_nxt = pending;
    if (wb_valid & wb_rd_en) pending_nxt[wb_rd] = 1'b0;
    if (issue & head.rd_en)  pending_nxt[head.rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (enq) mem[wr_ptr[PW-1:0]] <= '{serial: in_serial, rd_en: in_rd_en, rd: in_rd,
                                      rs2_en: in_rs2_en, rs2: in_rs2,
                                      rs1_en: in_rs1_en, rs1: in_rs1,
                                      payload: in_payload};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pending     <= '0;
      inflight    <= '0;
      serial_busy <= 1'b0;
      sb_err      <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (enq)   wr_ptr <= wr_ptr + PTR_ONE;
        if (issue) rd_ptr <= rd_ptr + PTR_ONE;
      end
      pending     <= pending_nxt;
      inflight    <= inflight_nxt;
      // Held until the window fully drains; a serial issue always re-arms it.
      serial_busy <= (serial_busy & (inflight_nxt != '0)) | (issue & head.serial);
      if (wb_valid & (inflight == '0)) sb_err <= 1'b1;
    end
  end
endmodule
